// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the PWM output block.
package pwm_pkg;

   // Number of driven pins: out[7:0] feeds uo_out, out[15:8] feeds uio_out.
   localparam int NUM_CH = 16;

   // Last value of the period counter; 255 is never reached so a period
   // spans 255 counter steps.
   localparam logic [7:0] PWM_CNT_MAX = 8'd254;

   // Duty code that means "always high" rather than "high for 255 steps".
   localparam logic [7:0] DUTY_FULL = 8'hFF;

   typedef logic [7:0] duty_t;

   // Per-pin configuration gathered from the two register pairs.
   typedef struct packed {
      logic [NUM_CH-1:0] en_out;
      logic [NUM_CH-1:0] en_pwm;
   } pin_cfg_t;

   // Raw waveform level for a given counter position and latched duty.
   // The full-scale code is special-cased so 0xFF has no low step at all.
   function automatic logic pwm_level(input duty_t cnt, input duty_t duty);
      return (duty == DUTY_FULL) || (cnt < duty);
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 0..254 period counter. Produces the counter value, a
// combinational wrap strobe (true in the cycle before the counter returns
// to 0) and a registered one-cycle period-start pulse.
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int unsigned CLK_DIV = 13
) (
   input  logic  clk,
   input  logic  rst,
   output duty_t pwm_cnt,
   output logic  wrap_tick,
   output logic  pwm_cycle_start
);

   // A divider of 1 still needs a 1-bit register so the ports stay legal.
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   assign tick      = (div_cnt == DIV_LAST);
   assign wrap_tick = tick && (pwm_cnt == PWM_CNT_MAX);

   // Prescaler: 0..CLK_DIV-1, one tick on the last count.
   always_ff @(posedge clk) begin
      if (rst)
         div_cnt <= '0;
      else if (tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   // Period counter: advance on tick, wrap 254 -> 0.
   always_ff @(posedge clk) begin
      if (rst)
         pwm_cnt <= '0;
      else if (wrap_tick)
         pwm_cnt <= '0;
      else if (tick)
         pwm_cnt <= pwm_cnt + 8'd1;
   end

   // Period-start pulse: high while the counter first reads 0 after a wrap.
   // Reset release leaves it low since no wrap has happened yet.
   always_ff @(posedge clk) begin
      if (rst)
         pwm_cycle_start <= 1'b0;
      else
         pwm_cycle_start <= wrap_tick;
   end

endmodule

// File: rtl/pwm_generator.sv
// Shared 8-bit PWM driving 16 pins. Each pin is forced low, held high, or
// follows the PWM waveform. The duty request is latched only at the period
// wrap so a mid-period write can never produce a runt pulse.
module pwm_generator
   import pwm_pkg::*;
#(
   parameter int unsigned CLK_DIV = 13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        pwm_cycle_start
);

   duty_t             pwm_cnt;
   duty_t             duty_shadow;
   logic              wrap_tick;
   logic              pwm_raw;
   pin_cfg_t          cfg;
   logic [NUM_CH-1:0] pin_nxt;

   pwm_timebase #(
      .CLK_DIV (CLK_DIV)
   ) u_timebase (
      .clk             (clk),
      .rst             (rst),
      .pwm_cnt         (pwm_cnt),
      .wrap_tick       (wrap_tick),
      .pwm_cycle_start (pwm_cycle_start)
   );

   // Enables are used directly (not shadowed) so pin mode changes take
   // effect on the next clock.
   assign cfg.en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign cfg.en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   // Duty shadow: capture the request on the wrap tick only. A request that
   // changes on that same cycle is taken as-is.
   always_ff @(posedge clk) begin
      if (rst)
         duty_shadow <= '0;
      else if (wrap_tick)
         duty_shadow <= pwm_duty_cycle;
   end

   assign pwm_raw = pwm_level(pwm_cnt, duty_shadow);

   // Per-pin mux: output enable wins over PWM select.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_pin
      assign pin_nxt[g] = cfg.en_out[g] & (cfg.en_pwm[g] ? pwm_raw : 1'b1);
   end

   // Registered pin drive keeps the pads glitch-free.
   always_ff @(posedge clk) begin
      if (rst)
         out <= '0;
      else
         out <= pin_nxt;
   end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator at CLK_DIV=13 (period 3315 clocks).
module tb_pwm_generator;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
   logic [15:0] out;
   logic        pcs;

   int tests = 0;
   int fails = 0;

   pwm_generator #(.CLK_DIV(13)) dut (
      .clk             (clk),
      .rst             (rst),
      .en_reg_out_7_0  (eo_lo),
      .en_reg_out_15_8 (eo_hi),
      .en_reg_pwm_7_0  (ep_lo),
      .en_reg_pwm_15_8 (ep_hi),
      .pwm_duty_cycle  (duty),
      .out             (out),
      .pwm_cycle_start (pcs)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
      {eo_hi, eo_lo} = eo;
      {ep_hi, ep_lo} = ep;
   endtask

   // Step until the period-start pulse; n = cycles taken (-1 on timeout),
   // nz = cycles where any output pin was high.
   task automatic wait_pcs(output int n, output int nz);
      n  = -1;
      nz = 0;
      for (int t = 1; t <= 4000; t++) begin
         step();
         if (out != 16'h0) nz++;
         if (pcs) begin
            n = t;
            break;
         end
      end
   endtask

   // Called right after a pulse sample: walks one full period of out[0]
   // (samples 1..len) counting high/low cycles. Optionally rewrites the
   // duty request at step chg_at.
   task automatic measure(input int chg_at, input logic [7:0] chg_val,
                          output int hi, output int lo, output int len,
                          output int rise);
      hi = 0; lo = 0; len = -1; rise = -1;
      for (int t = 1; t <= 4000; t++) begin
         if (t == chg_at) duty = chg_val;
         step();
         if (out[0]) begin
            hi++;
            if (rise < 0) rise = t;
         end else begin
            lo++;
         end
         if (pcs) begin
            len = t;
            break;
         end
      end
   endtask

   initial begin
      int n, nz, hi, lo, len, rise;

      // Reset with every input at 0xFF.
      rst = 1'b1;
      set_en(16'hFFFF, 16'hFFFF);
      duty = 8'hFF;
      repeat (3) step();
      chk("reset_out", int'(out), 0);
      chk("reset_pcs", int'(pcs), 0);

      // Shadow starts at 0, so PWM pins stay low until the first wrap.
      rst = 1'b0;
      wait_pcs(n, nz);
      chk("first_pcs_delay", n, 3315);
      chk("low_until_wrap", nz, 0);
      step();
      chk("full_after_wrap", int'(out), 16'hFFFF);

      // Static modes and one-cycle enable latency.
      set_en(16'h0000, 16'hFFFF);
      step();
      chk("en_out_priority", int'(out), 0);
      set_en(16'hFFFF, 16'h0000);
      chk("static_not_yet", int'(out), 0);
      step();
      chk("static_all", int'(out), 16'hFFFF);
      set_en(16'h00F0, 16'h0000);
      step();
      chk("static_00f0", int'(out), 16'h00F0);

      // 50% duty on pin 0.
      set_en(16'h0001, 16'h0001);
      duty = 8'h80;
      wait_pcs(n, nz);
      chk("sync_50", int'(n > 0), 1);
      measure(0, 8'h00, hi, lo, len, rise);
      chk("d80_rise", rise, 1);
      chk("d80_high", hi, 1664);
      chk("d80_low", lo, 1651);
      chk("d80_period", len, 3315);

      // Duty 0x00: two full periods constantly low.
      duty = 8'h00;
      wait_pcs(n, nz);
      measure(0, 8'h00, hi, lo, len, rise);
      chk("d00_high_p1", hi, 0);
      chk("d00_period", len, 3315);
      measure(0, 8'h00, hi, lo, len, rise);
      chk("d00_high_p2", hi, 0);

      // Mixed modes while PWM level is low: upper byte PWM, lower static.
      duty = 8'hFF;
      set_en(16'hFFFF, 16'hFF00);
      step();
      chk("mixed_modes", int'(out), 16'h00FF);
      set_en(16'h0001, 16'h0001);

      // Duty 0xFF: two full periods with no low cycle.
      wait_pcs(n, nz);
      measure(0, 8'h00, hi, lo, len, rise);
      chk("dff_low_p1", lo, 0);
      measure(0, 8'h00, hi, lo, len, rise);
      chk("dff_low_p2", lo, 0);
      chk("dff_period", len, 3315);

      // Shadowing: 0x40 period gets a mid-period write of 0xC0.
      duty = 8'h40;
      wait_pcs(n, nz);
      measure(1000, 8'hC0, hi, lo, len, rise);
      chk("shadow_keep_high", hi, 832);
      chk("shadow_keep_len", len, 3315);
      measure(0, 8'h00, hi, lo, len, rise);
      chk("shadow_next_high", hi, 2496);
      chk("shadow_next_low", lo, 819);

      // Reset in the middle of a high phase (counter near 100).
      repeat (1300) step();
      chk("pre_reset_high", int'(out[0]), 1);
      rst = 1'b1;
      step();
      chk("midreset_out", int'(out), 0);
      chk("midreset_pcs", int'(pcs), 0);
      rst = 1'b0;
      wait_pcs(n, nz);
      chk("post_reset_pcs_delay", n, 3315);
      chk("post_reset_low", nz, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
